tiny_dnn_src_framer: RTL and testbench

//  Upstream feeder for the accelerator source stream. Accepts raw 32-bit float words from the

---
 rtl/tiny_dnn_src_framer_if.sv | 22 ++
 rtl/tiny_dnn_src_framer.sv | 167 ++++++++++++++++
 tb/tb_tiny_dnn_src_framer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tiny_dnn_src_framer_if.sv
// Stream bundle for the source framer: upstream raw words in, framed words out to batch_ctrl.
interface tiny_dnn_src_framer_if #(
    parameter int unsigned DW = 32
) ();
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_last;
    logic          src_ready;

    modport master (
        input  s_valid, s_data, src_ready,
        output s_ready, src_valid, src_data, src_last
    );

    modport slave (
        output s_valid, s_data, src_ready,
        input  s_ready, src_valid, src_data, src_last
    );
endinterface

// File: rtl/tiny_dnn_src_framer.sv
// Source-stream framer: buffers host words in a small FIFO and emits them with src_last
// marking the end of every ss-word sample, for nfrm samples per run.
module tiny_dnn_src_framer #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [11:0]           ss,
    input  logic [15:0]           nfrm,
    tiny_dnn_src_framer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic [AW:0]           level
);
    localparam int unsigned SSW  = 12;
    localparam int unsigned NFW  = 16;
    localparam int unsigned REMW = 28;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [REMW-1:0] in_rem_q, in_rem_d;
    logic [SSW-1:0]  ss_q, ss_d, wcnt_q, wcnt_d;
    logic [NFW-1:0]  nfrm_q, nfrm_d, fcnt_q, fcnt_d;
    logic            s_ready_q, s_ready_d;
    logic            src_valid_q, src_valid_d;
    logic            src_last_q, src_last_d;
    logic [DW-1:0]   src_data_q, src_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            push_c, pop_c;

    // Next-state, FIFO bookkeeping and registered-output computation.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        in_rem_d    = in_rem_q;
        ss_d        = ss_q;
        nfrm_d      = nfrm_q;
        wcnt_d      = wcnt_q;
        fcnt_d      = fcnt_q;
        src_data_d  = src_data_q;
        push_c      = 1'b0;
        pop_c       = 1'b0;

        if (abort) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            in_rem_d   = '0;
            wcnt_d     = '0;
            fcnt_d     = '0;
            src_data_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ss_d     = ss;
                        nfrm_d   = nfrm;
                        in_rem_d = REMW'(ss) * REMW'(nfrm);
                        wcnt_d   = '0;
                        fcnt_d   = '0;
                        state_d  = (ss == '0 || nfrm == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    // s_ready_q/src_valid_q already encode RUN, occupancy and remaining input.
                    push_c = bus.s_valid && s_ready_q;
                    pop_c  = src_valid_q && bus.src_ready;
                    if (push_c) begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        in_rem_d = in_rem_q - REMW'(1);
                    end
                    if (pop_c) begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        if (src_last_q) begin
                            wcnt_d = '0;
                            fcnt_d = fcnt_q + NFW'(1);
                        end else begin
                            wcnt_d = wcnt_q + SSW'(1);
                        end
                    end
                    if (push_c && !pop_c) level_d = level_q + (AW+1)'(1);
                    else if (pop_c && !push_c) level_d = level_q - (AW+1)'(1);
                    if (pop_c && src_last_q && fcnt_q == nfrm_q - NFW'(1)) state_d = ST_DONE;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        s_ready_d   = (state_d == ST_RUN) && (level_d < FULL) && (in_rem_d != '0);
        src_valid_d = (state_d == ST_RUN) && (level_d != '0);
        src_last_d  = src_valid_d && (wcnt_d == ss_d - SSW'(1));
        busy_d      = (state_d == ST_RUN);
        done_d      = (state_d == ST_DONE);
        // A word written into an empty FIFO is forwarded straight into the output register.
        if (src_valid_d) begin
            src_data_d = (push_c && wr_ptr_q == rd_ptr_d) ? bus.s_data : mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_rem_q    <= '0;
            ss_q        <= '0;
            nfrm_q      <= '0;
            wcnt_q      <= '0;
            fcnt_q      <= '0;
            s_ready_q   <= 1'b0;
            src_valid_q <= 1'b0;
            src_last_q  <= 1'b0;
            src_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_rem_q    <= in_rem_d;
            ss_q        <= ss_d;
            nfrm_q      <= nfrm_d;
            wcnt_q      <= wcnt_d;
            fcnt_q      <= fcnt_d;
            s_ready_q   <= s_ready_d;
            src_valid_q <= src_valid_d;
            src_last_q  <= src_last_d;
            src_data_q  <= src_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Storage array carries no reset; occupancy tracking makes stale contents invisible.
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr_q] <= bus.s_data;
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.src_valid = src_valid_q;
    assign bus.src_last  = src_last_q;
    assign bus.src_data  = src_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign level         = level_q;
endmodule

// File: tb/tb_tiny_dnn_src_framer.sv
// Scoreboard bench for tiny_dnn_src_framer: accepted words are queued with their expected
// framing; a negedge monitor compares every downstream handshake and the status outputs.
module tb_tiny_dnn_src_framer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [11:0] ss;
    logic [15:0] nfrm;
    logic        busy, done;
    logic [4:0]  level;

    tiny_dnn_src_framer_if #(.DW(32)) bus ();

    tiny_dnn_src_framer #(.DW(32), .DEPTH(16), .AW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .ss    (ss),
        .nfrm  (nfrm),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done),
        .level (level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (owned by the monitor)
    logic [32:0] exp_q[$];
    bit          run_active   = 0;
    bit          done_pending = 0;
    int          total = 0, ss_m = 1, in_cnt = 0, out_cnt = 0, last_cnt = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_data;
    logic        prev_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare current outputs against the model, then apply this cycle's events.
    always @(negedge clk) begin
        bit          done_cur;
        logic [32:0] e;
        if (!rst_n) begin
            exp_q.delete();
            run_active   = 0;
            done_pending = 0;
            prev_hold    = 0;
        end
        check("busy", 32'(busy), 32'(run_active));
        check("done", 32'(done), 32'(done_pending));
        check("level", 32'(level), 32'(exp_q.size()));
        check("s_ready", 32'(bus.s_ready),
              32'(run_active && exp_q.size() < DEPTH && in_cnt < total));
        check("src_valid", 32'(bus.src_valid), 32'(run_active && exp_q.size() != 0));
        if (prev_hold) begin
            check("hold_valid", 32'(bus.src_valid), 32'd1);
            check("hold_data", bus.src_data, prev_data);
            check("hold_last", 32'(bus.src_last), 32'(prev_last));
        end
        done_cur     = done_pending;
        done_pending = 0;
        prev_hold    = 0;
        if (rst_n) begin
            if (abort) begin
                exp_q.delete();
                run_active = 0;
            end else begin
                if (bus.s_valid && bus.s_ready) begin
                    exp_q.push_back({((in_cnt % ss_m) == ss_m - 1), bus.s_data});
                    in_cnt++;
                end
                if (bus.src_valid && bus.src_ready) begin
                    if (exp_q.size() == 0) begin
                        check("pop_on_empty_model", 32'(bus.src_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("src_data", bus.src_data, e[31:0]);
                        check("src_last", 32'(bus.src_last), 32'(e[32]));
                    end
                    out_cnt++;
                    if (bus.src_last) last_cnt++;
                    if (out_cnt == total) begin
                        run_active   = 0;
                        done_pending = 1;
                    end
                end
                if (start && !run_active && !done_cur) begin
                    total    = int'(ss) * int'(nfrm);
                    ss_m     = (ss == 0) ? 1 : int'(ss);
                    in_cnt   = 0;
                    out_cnt  = 0;
                    last_cnt = 0;
                    if (total == 0) done_pending = 1;
                    else run_active = 1;
                end
                prev_hold = bus.src_valid && !bus.src_ready;
                prev_data = bus.src_data;
                prev_last = bus.src_last;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.s_data = $urandom;
    endtask

    task automatic do_start(input int s, input int n);
        cyc();
        start = 1'b1;
        ss    = 12'(s);
        nfrm  = 16'(n);
        cyc();
        start = 1'b0;
        ss    = 12'($urandom);
        nfrm  = 16'($urandom);
    endtask

    // mode 0: constant valid/ready; mode 1: 50% random on both sides
    task automatic run_to_idle(input int mode, input int budget);
        int k = 0;
        while ((run_active || done_pending) && k < budget) begin
            if (mode == 1) begin
                bus.s_valid   = 1'($urandom_range(0, 1));
                bus.src_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.s_valid   = 1'b1;
                bus.src_ready = 1'b1;
            end
            cyc();
            k++;
        end
        check("run_timeout", 32'(run_active || done_pending), 32'd0);
    endtask

    task automatic wait_in(input int n);
        int k = 0;
        while (in_cnt < n && k < 200) begin cyc(); k++; end
        check("wait_in_timeout", 32'(in_cnt >= n), 32'd1);
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (out_cnt < n && k < 200) begin cyc(); k++; end
        check("wait_out_timeout", 32'(out_cnt >= n), 32'd1);
    endtask

    task automatic test_basic();
        bus.s_valid = 1'b1; bus.src_ready = 1'b1;
        do_start(4, 2);
        run_to_idle(0, 100);
        repeat (5) cyc();
        check("t1_words", 32'(out_cnt), 32'd8);
        check("t1_lasts", 32'(last_cnt), 32'd2);
        check("t1_accepted", 32'(in_cnt), 32'd8);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ss = '0; nfrm = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.src_ready = 1'b0;
        #2;
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_src_valid", 32'(bus.src_valid), 32'd0);
        check("rst_src_data", bus.src_data, 32'd0);
        check("rst_level", 32'(level), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: in-order framing, done pulse, no over-acceptance
        test_basic();

        // 2a: input limited by ss*nfrm while downstream stalls
        bus.s_valid = 1'b1; bus.src_ready = 1'b0;
        do_start(3, 1);
        repeat (20) cyc();
        check("t2_level3", 32'(level), 32'd3);
        check("t2_sready_exhausted", 32'(bus.s_ready), 32'd0);
        run_to_idle(0, 50);

        // 2b: full FIFO blocks, one pop reopens s_ready
        bus.s_valid = 1'b1; bus.src_ready = 1'b0;
        do_start(20, 1);
        repeat (25) cyc();
        check("t2_level_full", 32'(level), 32'd16);
        check("t2_sready_full", 32'(bus.s_ready), 32'd0);
        bus.src_ready = 1'b1;
        cyc();
        bus.src_ready = 1'b0;
        check("t2_sready_recover", 32'(bus.s_ready), 32'd1);
        check("t2_level_after_pop", 32'(level), 32'd15);
        repeat (3) cyc();
        run_to_idle(0, 100);

        // 3: random handshakes
        do_start(7, 5);
        run_to_idle(1, 2000);
        check("t3_words", 32'(out_cnt), 32'd35);
        check("t3_lasts", 32'(last_cnt), 32'd5);
        for (int r = 0; r < 4; r++) begin
            int s_r, n_r;
            s_r = $urandom_range(1, 9);
            n_r = $urandom_range(1, 4);
            do_start(s_r, n_r);
            run_to_idle(1, 2000);
            check("rand_lasts", 32'(last_cnt), 32'(n_r));
        end

        // 4: degenerate runs finish immediately
        bus.s_valid = 1'b1; bus.src_ready = 1'b1;
        do_start(0, 3);
        run_to_idle(0, 10);
        do_start(2, 0);
        run_to_idle(0, 10);
        repeat (3) cyc();

        // 5: abort with 5 words in, 2 out, 3 buffered
        do_start(4, 4);
        bus.s_valid = 1'b1; bus.src_ready = 1'b0;
        wait_in(2);
        bus.s_valid = 1'b0; bus.src_ready = 1'b1;
        wait_out(2);
        bus.s_valid = 1'b1; bus.src_ready = 1'b0;
        wait_in(5);
        bus.s_valid = 1'b0;
        check("t5_level_pre", 32'(level), 32'd3);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("t5_level_post", 32'(level), 32'd0);
        check("t5_valid_post", 32'(bus.src_valid), 32'd0);
        repeat (3) cyc();
        bus.s_valid = 1'b1; bus.src_ready = 1'b1;
        do_start(2, 1);
        run_to_idle(0, 50);
        check("t5_words", 32'(out_cnt), 32'd2);

        // 6: asynchronous reset mid-run, then a clean rerun
        bus.s_valid = 1'b1; bus.src_ready = 1'b0;
        do_start(4, 2);
        repeat (3) cyc();
        #2 rst_n = 1'b0;
        #1;
        check("t6_s_ready", 32'(bus.s_ready), 32'd0);
        check("t6_src_valid", 32'(bus.src_valid), 32'd0);
        check("t6_src_data", bus.src_data, 32'd0);
        check("t6_level", 32'(level), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) cyc();
        test_basic();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
